// File: rtl/aliens_march_ctrl_pkg.sv
// Shared game constants for the alien-grid blocks: motion encodings, grid and
// screen dimensions, march FSM states and the step-direction decision.
package aliens_march_ctrl_pkg;

   localparam logic [1:0] MOT_HOLD  = 2'b00;
   localparam logic [1:0] MOT_RIGHT = 2'b01;
   localparam logic [1:0] MOT_LEFT  = 2'b10;
   localparam logic [1:0] MOT_DOWN  = 2'b11;

   localparam int unsigned NB_LIN   = 4;
   localparam int unsigned NB_COL   = 8;
   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_STEP = 2'd2;
   localparam logic [1:0] ST_HALT = 2'd3;

   typedef struct packed {
      logic [1:0] motion;
      logic       dir_right;
   } step_cmd_t;

   // A blocked active edge turns the step into a down step and reverses the sweep.
   function automatic step_cmd_t step_cmd(input logic dir_right,
                                          input logic can_left,
                                          input logic can_right);
      step_cmd_t c;
      if (dir_right && can_right) begin
         c.motion    = MOT_RIGHT;
         c.dir_right = 1'b1;
      end else if (!dir_right && can_left) begin
         c.motion    = MOT_LEFT;
         c.dir_right = 1'b0;
      end else begin
         c.motion    = MOT_DOWN;
         c.dir_right = ~dir_right;
      end
      return c;
   endfunction

endpackage

// File: rtl/aliens_march_ctrl_if.sv
// Bundle between the video/grid environment and the march controller.
interface aliens_march_ctrl_if;
   logic        run;
   logic [9:0]  hPos;
   logic [9:0]  vPos;
   logic        canLeft;
   logic        canRight;
   logic [31:0] alive;
   logic        victory;
   logic        defeat;
   logic [1:0]  motion;
   logic        stepTick;
   logic        dirRight;
   logic        halted;

   modport master (
      output run, hPos, vPos, canLeft, canRight, alive, victory, defeat,
      input  motion, stepTick, dirRight, halted
   );

   modport slave (
      input  run, hPos, vPos, canLeft, canRight, alive, victory, defeat,
      output motion, stepTick, dirRight, halted
   );
endinterface

// File: rtl/aliens_march_ctrl_popcount32.sv
// Combinational population count of a 32-bit mask; shared with the score block.
module popcount32 (
   input  logic [31:0] vec_i,
   output logic [5:0]  cnt_o
);

   // Sum of set bits.
   always_comb begin
      cnt_o = 6'd0;
      for (int i = 0; i < 32; i++) begin
         cnt_o = cnt_o + {5'd0, vec_i[i]};
      end
   end

endmodule

// File: rtl/aliens_march_ctrl.sv
// Alien march pacing: counts video frames, issues one-cycle right/left/down
// commands to the grid mover, accelerates as aliens die, freezes on game end.
module aliens_march_ctrl
   import aliens_march_ctrl_pkg::*;
#(
   parameter logic [9:0]  H_TICK      = 10'd0,
   parameter logic [9:0]  V_TICK      = 10'd480,
   parameter int unsigned MIN_FRAMES  = 2,
   parameter int unsigned SPEED_SHIFT = 1,
   parameter int unsigned CNT_W       = 8
) (
   input logic                clk,
   input logic                reset,
   aliens_march_ctrl_if.slave bus
);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             match_q;
   logic [1:0]       motion_q, motion_d;
   logic             step_tick_q, step_tick_d;
   logic             dir_right_q, dir_right_d;
   logic             halted_q, halted_d;

   logic             match_s;
   logic             frame_tick_s;
   logic [5:0]       alive_cnt_s;
   logic [CNT_W-1:0] period_s;
   logic [CNT_W:0]   cnt_inc_s;
   step_cmd_t        step_s;

   popcount32 u_popcount (
      .vec_i (bus.alive),
      .cnt_o (alive_cnt_s)
   );

   // Edge-detect the tick position so a slow pixel clock still yields one tick per frame.
   assign match_s      = (bus.hPos == H_TICK) && (bus.vPos == V_TICK);
   assign frame_tick_s = match_s & ~match_q;
   assign period_s     = CNT_W'(MIN_FRAMES) + CNT_W'(alive_cnt_s >> SPEED_SHIFT);
   assign cnt_inc_s    = {1'b0, frame_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign step_s       = step_cmd(dir_right_q, bus.canLeft, bus.canRight);

   // March FSM next state; game end overrides any pending step decision.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      motion_d    = MOT_HOLD;
      step_tick_d = 1'b0;
      dir_right_d = dir_right_q;
      halted_d    = halted_q;
      if (bus.victory || bus.defeat) begin
         state_d  = ST_HALT;
         halted_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.run) begin
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (bus.run && frame_tick_s) begin
                  if (cnt_inc_s < {1'b0, period_s}) begin
                     frame_cnt_d = cnt_inc_s[CNT_W-1:0];
                  end else begin
                     frame_cnt_d = {CNT_W{1'b0}};
                     state_d     = ST_STEP;
                     motion_d    = step_s.motion;
                     step_tick_d = 1'b1;
                     dir_right_d = step_s.dir_right;
                  end
               end else begin
                  frame_cnt_d = frame_cnt_q;
               end
            end
            ST_STEP: begin
               state_d = ST_WAIT;
            end
            ST_HALT: begin
               halted_d = 1'b1;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         frame_cnt_q <= {CNT_W{1'b0}};
         match_q     <= 1'b0;
         motion_q    <= MOT_HOLD;
         step_tick_q <= 1'b0;
         dir_right_q <= 1'b1;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         match_q     <= match_s;
         motion_q    <= motion_d;
         step_tick_q <= step_tick_d;
         dir_right_q <= dir_right_d;
         halted_q    <= halted_d;
      end
   end

   assign bus.motion   = motion_q;
   assign bus.stepTick = step_tick_q;
   assign bus.dirRight = dir_right_q;
   assign bus.halted   = halted_q;

endmodule

// File: tb/tb_aliens_march_ctrl.sv
// Scoreboard bench for aliens_march_ctrl: a frame-level model predicts each
// step (command, direction, cycle); a monitor checks every step the DUT emits.
module tb_aliens_march_ctrl;

   localparam logic [9:0] H_TICK     = 10'd0;
   localparam logic [9:0] V_TICK     = 10'd480;
   localparam int         MIN_FRAMES = 2;

   typedef struct {
      logic [1:0] mot;
      bit         dir;
      int         cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;
   exp_t sb[$];

   int   m_cnt;
   bit   m_dir;
   bit   m_halt;
   bit   halt_chk;

   aliens_march_ctrl_if bus ();

   aliens_march_ctrl #(
      .H_TICK      (H_TICK),
      .V_TICK      (V_TICK),
      .MIN_FRAMES  (MIN_FRAMES),
      .SPEED_SHIFT (1),
      .CNT_W       (8)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
      end
   endfunction

   // Monitor: every emitted step must match the oldest prediction; overdue predictions are misses.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("missing_step_at_cycle", cyc, e.cyc);
         end
         if (bus.motion !== 2'b00 || bus.stepTick !== 1'b0) begin
            if (sb.size() == 0) begin
               chk("unexpected_step_motion", int'(bus.motion), 0);
            end else begin
               e = sb.pop_front();
               chk("step_motion", int'(bus.motion), int'(e.mot));
               chk("step_tick", int'(bus.stepTick), 1);
               chk("step_dir_right", int'(bus.dirRight), int'(e.dir));
               chk("step_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_cnt  = 0;
      m_dir  = 1'b1;
      m_halt = 1'b0;
      sb.delete();
   endtask

   // Frame-level rule: each counted frame tick advances; reaching the period emits one step.
   task automatic model_tick(output bit stepped);
      int   per;
      exp_t e;
      stepped = 1'b0;
      if (m_halt) return;
      if (bus.victory || bus.defeat) begin
         m_halt = 1'b1;
         return;
      end
      if (!bus.run) return;
      per   = MIN_FRAMES + ($countones(bus.alive) >> 1);
      m_cnt = m_cnt + 1;
      if (m_cnt >= per) begin
         m_cnt = 0;
         if (m_dir && bus.canRight)       e.mot = 2'b01;
         else if (!m_dir && bus.canLeft)  e.mot = 2'b10;
         else begin
            e.mot = 2'b11;
            m_dir = !m_dir;
         end
         e.dir = m_dir;
         e.cyc = cyc + 1;
         sb.push_back(e);
         stepped = 1'b1;
      end
   endtask

   function automatic int model_period();
      return MIN_FRAMES + ($countones(bus.alive) >> 1);
   endfunction

   task automatic next_cyc();
      @(negedge clk);
      bus.defeat = 1'b0;
      if (halt_chk) begin
         halt_chk = 1'b0;
         chk("halted_after_defeat", int'(bus.halted), 1);
         chk("motion_after_defeat", int'(bus.motion), 0);
      end
   endtask

   task automatic pix(input logic [9:0] h, input logic [9:0] v, input int div);
      for (int k = 0; k < div; k++) begin
         next_cyc();
         bus.hPos = h;
         bus.vPos = v;
      end
   endtask

   // One compressed video frame: off-tick pixels, the tick pixel, then more blanking pixels.
   task automatic frame(input int div, input bit r, input logic [31:0] al,
                        input bit cl, input bit cr, input bit dft, input bit rst_on_step);
      bit stepped;
      bus.run      = r;
      bus.alive    = al;
      bus.canLeft  = cl;
      bus.canRight = cr;
      for (int p = 0; p < 3; p++)
         pix(10'($urandom_range(0, 799)), 10'($urandom_range(0, 479)), div);
      for (int k = 0; k < div; k++) begin
         next_cyc();
         bus.hPos = H_TICK;
         bus.vPos = V_TICK;
         if (k == 0) begin
            bus.defeat = dft;
            model_tick(stepped);
            if (dft) halt_chk = 1'b1;
            if (rst_on_step && stepped) begin
               next_cyc();
               #1 rst_n = 1'b0;
               #1;
               chk("async_reset_motion", int'(bus.motion), 0);
               chk("async_reset_step_tick", int'(bus.stepTick), 0);
               chk("async_reset_dir_right", int'(bus.dirRight), 1);
               model_reset();
            end
         end
      end
      for (int p = 0; p < 2; p++)
         pix(10'($urandom_range(1, 799)), V_TICK, div);
   endtask

   initial begin
      logic [31:0] al;
      int          n;
      cyc          = 0;
      checks       = 0;
      errors       = 0;
      halt_chk     = 1'b0;
      rst_n        = 1'b0;
      bus.run      = 1'b0;
      bus.hPos     = 10'd5;
      bus.vPos     = 10'd0;
      bus.canLeft  = 1'b1;
      bus.canRight = 1'b1;
      bus.alive    = 32'hFFFF_FFFF;
      bus.victory  = 1'b0;
      bus.defeat   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_motion", int'(bus.motion), 0);
      chk("reset_step_tick", int'(bus.stepTick), 0);
      chk("reset_dir_right", int'(bus.dirRight), 1);
      chk("reset_halted", int'(bus.halted), 0);
      bus.run = 1'b1;
      rst_n   = 1'b1;

      // Full grid: right steps every 18 frames, blocked right edge, then left sweep.
      for (int f = 0; f < 40; f++) frame(1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int f = 0; f < 20; f++) frame(1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int f = 0; f < 18; f++) frame(1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);

      // Speed-up: four aliens left, then a single one.
      for (int f = 0; f < 12; f++) frame(1, 1'b1, 32'h0000_000F, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int f = 0; f < 8; f++)  frame(1, 1'b1, 32'h0000_0020, 1'b1, 1'b1, 1'b0, 1'b0);

      // Pause mid-count at seven frames, then resume.
      n = 0;
      while (m_cnt != 7 && n < 40) begin
         frame(1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
         n++;
      end
      for (int f = 0; f < 5; f++)  frame(2, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int f = 0; f < 15; f++) frame(1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);

      // Defeat on the completing tick suppresses the step and halts for good.
      n = 0;
      while (m_cnt != 17 && n < 40) begin
         frame(1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
         n++;
      end
      frame(1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int f = 0; f < 6; f++) frame(1, 1'b1, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("halted_persists", int'(bus.halted), 1);

      next_cyc();
      rst_n = 1'b0;
      repeat (2) next_cyc();
      chk("halted_cleared_by_reset", int'(bus.halted), 0);
      model_reset();
      rst_n = 1'b1;

      // Randomized march: pixel clock divider 1..4, sporadic pauses, random grid and edges.
      for (int f = 0; f < 150; f++) begin
         al = $urandom;
         if ($urandom_range(0, 9) == 0) al = 32'h0;
         else if ($urandom_range(0, 9) == 0) al = 32'h1 << $urandom_range(0, 31);
         frame($urandom_range(1, 4), ($urandom_range(0, 7) != 0), al,
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
      end

      // Force a left step at four cycles per pixel and hit reset while it is on the bus.
      n = 0;
      while (!(m_dir == 1'b0 && m_cnt == 1) && n < 30) begin
         frame(4, 1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 1'b0);
         n++;
      end
      frame(4, 1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 1'b1);
      next_cyc();
      rst_n   = 1'b1;
      bus.run = 1'b1;
      for (int f = 0; f < 6; f++) frame(4, 1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 1'b0);

      repeat (10) next_cyc();
      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aliens_march_ctrl.md
Name: aliens_march_ctrl

Overview:
- Upstream stage of the alien-grid mover. Generates the 2-bit `motion` command that the mover applies once per clock.
- Paces the march in video frames, derived from hPos/vPos. Sweeps right and left, steps down when the active edge is blocked, and speeds up as aliens die.
- Freezes the march permanently on victory or defeat.

Parameters:
- H_TICK, 10'd0, hPos value that marks the frame tick.
- V_TICK, 10'd480, vPos value that marks the frame tick (first blanking line).
- MIN_FRAMES, 2, frames per step when one alien is left.
- SPEED_SHIFT, 1, period = MIN_FRAMES + (popcount(alive) >> SPEED_SHIFT).
- CNT_W, 8, width of the frame counter.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- run  in  1  march enable; 0 freezes pacing
- hPos  in  10  current horizontal pixel
- vPos  in  10  current vertical line
- canLeft  in  1  grid may move toward smaller x
- canRight  in  1  grid may move toward larger x
- alive  in  32  alien alive mask, bit = row*8+col
- victory  in  1  all aliens dead
- defeat  in  1  grid reached the bottom limit
- motion  out  2  00 hold, 01 x+ (right), 10 x− (left), 11 y+ (down)
- stepTick  out  1  one-cycle pulse, coincident with any nonzero motion
- dirRight  out  1  current horizontal direction (1 = right)
- halted  out  1  march permanently stopped

Behaviour:
- Reset (reset==0, async) sets:
  - state=IDLE, motion=00, stepTick=0, dirRight=1, halted=0, frameCnt=0, match_d=0.
- Frame tick:
  - match = (hPos==H_TICK && vPos==V_TICK); match_d is its registered copy.
  - frameTick = match & ~match_d. This gives one pulse per frame even when clk runs faster than the pixel rate.
- Period:
  - period = MIN_FRAMES + (popcount(alive) >> SPEED_SHIFT), evaluated combinationally at each frameTick.
  - With defaults: 32 alive → 18 frames; 1 alive → 2 frames.
  - Width CNT_W; no overflow for the default values.
- FSM states: IDLE, WAIT, STEP, HALT.
  - IDLE: go to WAIT when run=1.
  - WAIT, run=0: frameCnt held, no step issued.
  - WAIT, frameTick with frameCnt+1 < period: frameCnt increments.
  - WAIT, frameTick with frameCnt+1 >= period: frameCnt←0, go to STEP. The command is registered in that same edge.
    - dirRight=1 & canRight=1 → 01.
    - dirRight=0 & canLeft=1 → 10.
    - Otherwise → 11, and dirRight toggles.
  - STEP: lasts exactly one cycle; motion and stepTick are valid in this cycle. Next state is WAIT, with motion←00 and stepTick←0.
  - HALT: absorbing. motion=00, halted=1. Left only by reset.
- Latency: nonzero motion appears in the cycle immediately after the frameTick cycle, for exactly 1 cycle.
- Halt priority:
  - victory|defeat high in any state → HALT at the next edge.
  - This beats a simultaneous step decision: that step is not issued and motion stays 00.
- canLeft/canRight are sampled only at the step decision. The consumer's flags settle within 2 cycles, well inside one frame.
- If canLeft=canRight=0, every step is a down step and direction alternates. This is legal and not an error.
- alive==0 without victory: period=MIN_FRAMES and the march continues.
- Reset asserted mid-STEP: motion drops to 00 immediately (async).

Decomposition:
- Shared game package holds:
  - motion encodings MOT_HOLD=2'b00, MOT_RIGHT=2'b01, MOT_LEFT=2'b10, MOT_DOWN=2'b11;
  - grid constants NB_LIN=4, NB_COL=8;
  - screen constants 640/480.
- One sub-module: popcount32 (combinational, 32-bit in, 6-bit out). It is reusable by the score block.

Test Plan:
- Release reset with run=1, alive=all-ones, canRight=1, hPos/vPos counting a 800x525 frame → first motion=01 for 1 cycle after the 18th frame tick; then every 18 frames.
- canRight=0 at a step decision with dirRight=1 → motion=11, dirRight becomes 0. The next step (18 frames later, canLeft=1) is 10.
- Alive count 32→4, then 1 alive (bit 5) → period 2+2=4 frames, then 2 frames. Check the stepTick spacing.
- run=0 for 5 frames mid-count at frameCnt=7 → no stepTick; frameCnt resumes from 7 when run=1.
- defeat=1 in the same cycle as a completing frameTick → motion stays 00, halted=1 next cycle. No further steps until reset.
- reset=0 asserted while motion=10 → motion=00 and dirRight=1 immediately. Hold clk at 4 cycles per pixel → still exactly one frameTick per frame.
